fwd_hazard_unit: RTL

Parametrised EX-stage forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It generalises the single 3:1 forwarding mux to N_SRC operands. It generates the select codes and the forwarded operand data itself, so no external forwarding mux is needed. It also owns a multi-cycle load-use stall FSM (LOAD_LAT cycles), branch-flush abort, and saturating forward/stall statistics counters.

---
 rtl/fwd_hazard_if.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fwd_hazard_if.sv
// Bundle of EX/ID pipeline signals seen by the forwarding/hazard unit.
// The master drives the pipeline inputs; the slave (the unit) drives select, data, stall and stats.
interface fwd_hazard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned CNT_W  = 16
);
    logic [N_SRC*REG_AW-1:0] ex_src_addr;
    logic [N_SRC*DATA_W-1:0] ex_src_data;
    logic                    ex_mem_wr_en;
    logic [REG_AW-1:0]       ex_mem_rd;
    logic [DATA_W-1:0]       ex_mem_result;
    logic                    mem_wb_wr_en;
    logic [REG_AW-1:0]       mem_wb_rd;
    logic [DATA_W-1:0]       mem_wb_result;
    logic [N_SRC*REG_AW-1:0] id_src_addr;
    logic [N_SRC-1:0]        id_src_used;
    logic                    id_ex_is_load;
    logic                    id_ex_wr_en;
    logic [REG_AW-1:0]       id_ex_rd;
    logic                    flush;
    logic                    cnt_clr;
    logic [N_SRC*2-1:0]      fwd_sel;
    logic [N_SRC*DATA_W-1:0] fwd_data;
    logic                    stall;
    logic [CNT_W-1:0]        fwd_cnt;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output ex_src_addr, ex_src_data, ex_mem_wr_en, ex_mem_rd, ex_mem_result,
               mem_wb_wr_en, mem_wb_rd, mem_wb_result, id_src_addr, id_src_used,
               id_ex_is_load, id_ex_wr_en, id_ex_rd, flush, cnt_clr,
        input  fwd_sel, fwd_data, stall, fwd_cnt, stall_cnt
    );

    modport slave (
        input  ex_src_addr, ex_src_data, ex_mem_wr_en, ex_mem_rd, ex_mem_result,
               mem_wb_wr_en, mem_wb_rd, mem_wb_result, id_src_addr, id_src_used,
               id_ex_is_load, id_ex_wr_en, id_ex_rd, flush, cnt_clr,
        output fwd_sel, fwd_data, stall, fwd_cnt, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding with built-in data muxes, multi-cycle load-use stall FSM,
// branch-flush abort and saturating forward/stall statistics.
module fwd_hazard_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned N_SRC    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  bus
);
    localparam int unsigned LatW    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int unsigned LatLoad = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;

    typedef enum logic {StIdle, StStall} state_e;

    state_e                  state_q, state_d;
    logic [LatW-1:0]         lat_q, lat_d;
    logic [CNT_W-1:0]        fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [N_SRC*2-1:0]      fwd_sel;
    logic [N_SRC*DATA_W-1:0] fwd_data;
    logic                    any_fwd;
    logic                    src_match;
    logic                    hit;
    logic                    stall_raw;
    logic                    stall;

    // EX/MEM is checked first so the youngest producer wins; r0 never forwards.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        any_fwd  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.ex_mem_wr_en && (bus.ex_mem_rd != '0) &&
                (bus.ex_mem_rd == bus.ex_src_addr[i*REG_AW +: REG_AW])) begin
                fwd_sel[i*2 +: 2]         = 2'b10;
                fwd_data[i*DATA_W +: DATA_W] = bus.ex_mem_result;
                any_fwd                   = 1'b1;
            end else if (bus.mem_wb_wr_en && (bus.mem_wb_rd != '0) &&
                         (bus.mem_wb_rd == bus.ex_src_addr[i*REG_AW +: REG_AW])) begin
                fwd_sel[i*2 +: 2]         = 2'b01;
                fwd_data[i*DATA_W +: DATA_W] = bus.mem_wb_result;
                any_fwd                   = 1'b1;
            end else begin
                fwd_sel[i*2 +: 2]         = 2'b00;
                fwd_data[i*DATA_W +: DATA_W] = bus.ex_src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.id_src_used[i] && (bus.id_src_addr[i*REG_AW +: REG_AW] == bus.id_ex_rd)) begin
                src_match = 1'b1;
            end
        end
    end

    assign hit = bus.id_ex_is_load & bus.id_ex_wr_en & (bus.id_ex_rd != '0) & src_match;

    // The first stall cycle is spent in StIdle, so StStall covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_raw = hit & ~bus.flush;
                if (hit && !bus.flush && (LOAD_LAT > 1)) begin
                    state_d = StStall;
                    lat_d   = LatW'(LatLoad);
                end
            end
            StStall: begin
                stall_raw = ~bus.flush;
                if (bus.flush) begin
                    state_d = StIdle;
                    lat_d   = '0;
                end else if (lat_q == '0) begin
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                lat_d   = '0;
            end
        endcase
    end

    // Reset must kill the stall immediately, even while a hit is still presented.
    assign stall = rst_n & stall_raw;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr) begin
            fwd_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (any_fwd && (fwd_cnt_q != '1)) begin
                fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel   = fwd_sel;
    assign bus.fwd_data  = fwd_data;
    assign bus.stall     = stall;
    assign bus.fwd_cnt   = fwd_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
